// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive framing path: FSM states,
// default framing constants and the running checksum step.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE     = 8'hA5;
    localparam int         DEF_TIMEOUT_TICKS = 320;

    // 8-bit wrapping additive checksum step.
    function automatic logic [7:0] uart_chk_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to the command decoder.
interface uart_rx_frame_ctrl_if;

    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_last;
    logic       pkt_ready;
    logic [7:0] pkt_len;

    modport master (output pkt_data, pkt_valid, pkt_last, pkt_len, input pkt_ready);
    modport slave  (input pkt_data, pkt_valid, pkt_last, pkt_len, output pkt_ready);

endinterface

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload buffer: register array, synchronous write, asynchronous read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind the UART RX core: SYNC, LEN, PAYLOAD, CHK. Verified
// payloads are drained over a valid/ready stream; bad frames raise pulses.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_error,
    input  logic                 baud_tick_16x,
    uart_rx_frame_ctrl_if.master pkt,
    output logic                 busy,
    output logic                 chk_err,
    output logic                 len_err,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic                 overrun_err
);

    localparam int              PW        = $clog2(MAX_LEN + 1);
    localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              TW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_TICKS - 1);

    state_t        state_q, state_n;
    logic [7:0]    len_q, acc_q, rd_data;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] to_cnt;
    logic          ld_len, wr_en, ld_drain, rd_inc, to_hit, wr_last, rd_last;
    logic          chk_err_n, len_err_n, frame_err_n, timeout_err_n, overrun_err_n;

    assign wr_last = (8'(wr_ptr) == len_q - 8'd1);
    assign rd_last = (8'(rd_ptr) == len_q - 8'd1);
    assign to_hit  = baud_tick_16x && (to_cnt == TO_LAST);

    always_comb begin
        state_n       = state_q;
        ld_len        = 1'b0;
        wr_en         = 1'b0;
        ld_drain      = 1'b0;
        rd_inc        = 1'b0;
        chk_err_n     = 1'b0;
        len_err_n     = 1'b0;
        frame_err_n   = 1'b0;
        timeout_err_n = 1'b0;
        overrun_err_n = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (rx_error) frame_err_n = 1'b1;
                else if (rx_valid && rx_data == SYNC_BYTE) state_n = ST_LEN;
            end
            ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                // Stop-bit error beats a byte in the same cycle; a byte beats a tick.
                if (rx_error) begin
                    frame_err_n = 1'b1;
                    state_n     = ST_HUNT;
                end else if (rx_valid) begin
                    if (state_q == ST_LEN) begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            len_err_n = 1'b1;
                            state_n   = ST_HUNT;
                        end else begin
                            ld_len  = 1'b1;
                            state_n = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        wr_en = 1'b1;
                        if (wr_last) state_n = ST_CHECK;
                    end else if (rx_data == acc_q) begin
                        ld_drain = 1'b1;
                        state_n  = ST_DRAIN;
                    end else begin
                        chk_err_n = 1'b1;
                        state_n   = ST_HUNT;
                    end
                end else if (to_hit) begin
                    timeout_err_n = 1'b1;
                    state_n       = ST_HUNT;
                end
            end
            ST_DRAIN: begin
                // The buffer is busy draining, so any new byte is dropped.
                if (rx_valid && !rx_error) overrun_err_n = 1'b1;
                if (pkt.pkt_ready) begin
                    rd_inc = 1'b1;
                    if (rd_last) state_n = ST_HUNT;
                end
            end
            default: state_n = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            len_q       <= 8'd0;
            acc_q       <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            to_cnt      <= '0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state_q     <= state_n;
            chk_err     <= chk_err_n;
            len_err     <= len_err_n;
            frame_err   <= frame_err_n;
            timeout_err <= timeout_err_n;
            overrun_err <= overrun_err_n;
            if (ld_len) begin
                len_q  <= rx_data;
                acc_q  <= rx_data;
                wr_ptr <= '0;
            end
            if (wr_en) begin
                acc_q  <= uart_chk_add(acc_q, rx_data);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (ld_drain) rd_ptr <= '0;
            if (rd_inc)   rd_ptr <= rd_ptr + PW'(1);
            if (state_q == ST_HUNT || state_q == ST_DRAIN || rx_valid || timeout_err_n)
                to_cnt <= '0;
            else if (baud_tick_16x)
                to_cnt <= to_cnt + TW'(1);
        end
    end

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign busy          = (state_q != ST_HUNT);
    assign pkt.pkt_valid = (state_q == ST_DRAIN);
    assign pkt.pkt_data  = pkt.pkt_valid ? rd_data : 8'h00;
    assign pkt.pkt_last  = pkt.pkt_valid && rd_last;
    assign pkt.pkt_len   = pkt.pkt_valid ? len_q : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed plus randomized checks of the frame controller against a
// byte-stream parsing model.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO      = 320;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] beat_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       baud_tick_16x = 1'b0;
    logic       busy, chk_err, len_err, frame_err, timeout_err, overrun_err;

    uart_rx_frame_ctrl_if pkt_if();

    uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .baud_tick_16x (baud_tick_16x),
        .pkt           (pkt_if),
        .busy          (busy),
        .chk_err       (chk_err),
        .len_err       (len_err),
        .frame_err     (frame_err),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    beat_q_t got_q;
    int n_chk, n_len, n_frame, n_to, n_ovr;
    int n_assert, n_fail;
    int base, e0;

    // Observe transfers and pulses on the falling edge, where everything is settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_if.pkt_valid && pkt_if.pkt_ready) got_q.push_back({pkt_if.pkt_last, pkt_if.pkt_data});
            if (chk_err)     n_chk++;
            if (len_err)     n_len++;
            if (frame_err)   n_frame++;
            if (timeout_err) n_to++;
            if (overrun_err) n_ovr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int errs();
        return n_chk + n_len + n_frame + n_to + n_ovr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick_clk();
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
    endtask

    task automatic drain(input bit rnd);
        int guard;
        guard = 0;
        while (pkt_if.pkt_valid && guard < 200) begin
            pkt_if.pkt_ready = rnd ? 1'($urandom) : 1'b1;
            tick_clk();
            guard++;
        end
        if (guard >= 200) chk("drain_bound", 32'(pkt_if.pkt_valid), 32'd0);
        pkt_if.pkt_ready = 1'b1;
    endtask

    // Reference: walk the byte stream frame by frame using the framing rules.
    function automatic void model(input byte_q_t s, output beat_q_t p, output int nc, output int nl);
        int i, len, sum;
        p = {};
        nc = 0;
        nl = 0;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) break;
            len = int'(s[i]);
            i++;
            if (len == 0 || len > MAX_LEN) begin
                nl++;
                continue;
            end
            if (i + len >= s.size()) break;
            sum = len;
            for (int k = 0; k < len; k++) sum += int'(s[i+k]);
            if (s[i+len] == 8'(sum % 256)) begin
                for (int k = 0; k < len; k++) p.push_back({(k == len - 1), s[i+k]});
            end else begin
                nc++;
            end
            i += len + 1;
        end
    endfunction

    initial begin
        logic [7:0] sd, sn;
        logic       sl;
        logic [8:0] exp3 [3];
        byte_q_t    stream;
        beat_q_t    exp_q;
        int         exp_chk, exp_len, kind, len, sum, nb, c0, l0, f0, t0, o0;

        pkt_if.pkt_ready = 1'b1;
        repeat (3) tick_clk();
        chk("reset_flags", 32'({pkt_if.pkt_valid, pkt_if.pkt_last, busy, chk_err, len_err,
                                frame_err, timeout_err, overrun_err}), 32'd0);
        chk("reset_data", 32'({pkt_if.pkt_data, pkt_if.pkt_len}), 32'd0);
        rst = 1'b0;
        tick_clk();

        // Good frame, ready held high.
        base = got_q.size();
        e0 = errs();
        send_bytes(64'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}), 5);
        chk("good_no_valid_early", 32'(pkt_if.pkt_valid), 32'd0);
        send_byte(8'h69);
        chk("good_valid_first", 32'(pkt_if.pkt_valid), 32'd1);
        chk("good_d0", 32'(pkt_if.pkt_data), 32'h11);
        chk("good_len", 32'(pkt_if.pkt_len), 32'd3);
        chk("good_last0", 32'(pkt_if.pkt_last), 32'd0);
        tick_clk();
        chk("good_d1", 32'(pkt_if.pkt_data), 32'h22);
        tick_clk();
        chk("good_d2", 32'(pkt_if.pkt_data), 32'h33);
        chk("good_last2", 32'(pkt_if.pkt_last), 32'd1);
        tick_clk();
        chk("good_done", 32'({pkt_if.pkt_valid, busy}), 32'd0);
        tick_clk();
        chk("good_beats", 32'(got_q.size() - base), 32'd3);
        chk("good_noerr", 32'(errs() - e0), 32'd0);

        // Bad checksum, then a one-byte good frame.
        e0 = n_chk;
        send_bytes(64'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A}), 6);
        chk("badchk_pulse", 32'(chk_err), 32'd1);
        chk("badchk_novalid", 32'(pkt_if.pkt_valid), 32'd0);
        tick_clk();
        chk("badchk_width", 32'(chk_err), 32'd0);
        base = got_q.size();
        send_bytes(64'({8'hA5, 8'h01, 8'h7E, 8'h7F}), 4);
        drain(1'b0);
        tick_clk();
        chk("badchk_count", 32'(n_chk - e0), 32'd1);
        chk("after_bad_size", 32'(got_q.size() - base), 32'd1);
        chk("after_bad_beat", 32'(got_q[base]), 32'h17E);

        // Garbage ahead of a frame, then length errors.
        base = got_q.size();
        e0 = errs();
        send_bytes(64'({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}), 6);
        drain(1'b0);
        tick_clk();
        chk("garbage_size", 32'(got_q.size() - base), 32'd1);
        chk("garbage_beat", 32'(got_q[base]), 32'h17E);
        chk("garbage_noerr", 32'(errs() - e0), 32'd0);
        e0 = n_len;
        send_bytes(64'({8'hA5, 8'h00}), 2);
        chk("len_zero", 32'({len_err, busy}), 32'b10);
        send_bytes(64'({8'hA5, 8'h11}), 2);
        chk("len_over", 32'({len_err, busy}), 32'b10);
        tick_clk();
        chk("len_count", 32'(n_len - e0), 32'd2);

        // Timeout after exactly TO ticks of silence.
        e0 = n_to;
        send_bytes(64'({8'hA5, 8'h02, 8'h11}), 3);
        baud_tick_16x = 1'b1;
        repeat (TO - 1) tick_clk();
        chk("to_not_yet", 32'({timeout_err, busy}), 32'b01);
        tick_clk();
        baud_tick_16x = 1'b0;
        chk("to_pulse", 32'({timeout_err, busy}), 32'b10);
        tick_clk();
        chk("to_count", 32'(n_to - e0), 32'd1);

        // A byte arriving just before the limit keeps the frame alive.
        e0 = n_to;
        base = got_q.size();
        send_bytes(64'({8'hA5, 8'h02, 8'h11}), 3);
        baud_tick_16x = 1'b1;
        repeat (TO - 1) tick_clk();
        baud_tick_16x = 1'b0;
        send_byte(8'h22);
        chk("to_saved_busy", 32'(busy), 32'd1);
        baud_tick_16x = 1'b1;
        repeat (TO - 1) tick_clk();
        baud_tick_16x = 1'b0;
        send_byte(8'h35);
        chk("to_saved_valid", 32'(pkt_if.pkt_valid), 32'd1);
        drain(1'b0);
        tick_clk();
        chk("to_saved_count", 32'(n_to - e0), 32'd0);
        chk("to_saved_beats", 32'({got_q[base], got_q[base+1]}), 32'({9'h011, 9'h122}));

        // Backpressure: ready toggles, outputs hold while stalled.
        pkt_if.pkt_ready = 1'b0;
        base = got_q.size();
        send_bytes(64'({8'hA5, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h34}), 6);
        for (int i = 0; i < 12 && pkt_if.pkt_valid; i++) begin
            pkt_if.pkt_ready = i[0];
            sd = pkt_if.pkt_data;
            sl = pkt_if.pkt_last;
            sn = pkt_if.pkt_len;
            tick_clk();
            if (!pkt_if.pkt_ready)
                chk("stall_stable", 32'({pkt_if.pkt_valid, pkt_if.pkt_last, pkt_if.pkt_len, pkt_if.pkt_data}),
                    32'({1'b1, sl, sn, sd}));
        end
        pkt_if.pkt_ready = 1'b1;
        tick_clk();
        exp3 = '{9'h0AA, 9'h0BB, 9'h1CC};
        chk("bp_size", 32'(got_q.size() - base), 32'd3);
        for (int k = 0; k < 3; k++) chk("bp_beat", 32'(got_q[base+k]), 32'(exp3[k]));

        // Overrun: two bytes land while the buffer drains.
        e0 = n_ovr;
        pkt_if.pkt_ready = 1'b0;
        base = got_q.size();
        send_bytes(64'({8'hA5, 8'h02, 8'h10, 8'h20, 8'h32}), 5);
        send_byte(8'hA5);
        chk("ovr_pulse1", 32'(overrun_err), 32'd1);
        send_byte(8'h55);
        chk("ovr_pulse2", 32'(overrun_err), 32'd1);
        drain(1'b0);
        tick_clk();
        chk("ovr_count", 32'(n_ovr - e0), 32'd2);
        chk("ovr_payload", 32'({got_q[base], got_q[base+1]}), 32'({9'h010, 9'h120}));
        chk("ovr_idle", 32'(busy), 32'd0);

        // Stop-bit error mid-frame.
        e0 = n_frame;
        send_bytes(64'({8'hA5, 8'h03, 8'h11}), 3);
        rx_error = 1'b1;
        tick_clk();
        rx_error = 1'b0;
        chk("frame_err", 32'({frame_err, busy}), 32'b10);
        tick_clk();
        chk("frame_count", 32'(n_frame - e0), 32'd1);

        // Reset in the middle of a drain.
        pkt_if.pkt_ready = 1'b0;
        send_bytes(64'({8'hA5, 8'h01, 8'h7E, 8'h7F}), 4);
        chk("rst_pre_valid", 32'(pkt_if.pkt_valid), 32'd1);
        rst = 1'b1;
        tick_clk();
        chk("rst_mid_drain", 32'({pkt_if.pkt_valid, busy}), 32'd0);
        rst = 1'b0;
        pkt_if.pkt_ready = 1'b1;
        tick_clk();
        base = got_q.size();
        send_bytes(64'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6);
        drain(1'b0);
        tick_clk();
        chk("rst_after_size", 32'(got_q.size() - base), 32'd3);
        chk("rst_after_last", 32'(got_q[base+2]), 32'h133);

        // Random frame mix checked against the stream model.
        stream = {};
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                len = int'($urandom_range(1, MAX_LEN));
                stream.push_back(8'hA5);
                stream.push_back(8'(len));
                sum = len;
                for (int k = 0; k < len; k++) begin
                    nb = int'($urandom_range(0, 255));
                    stream.push_back(8'(nb));
                    sum += nb;
                end
                stream.push_back(kind == 0 ? 8'(sum) : 8'(sum + 1));
            end else if (kind == 2) begin
                stream.push_back(8'hA5);
                stream.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                nb = int'($urandom_range(1, 3));
                for (int k = 0; k < nb; k++) stream.push_back(8'($urandom));
            end
        end
        model(stream, exp_q, exp_chk, exp_len);
        base = got_q.size();
        c0 = n_chk; l0 = n_len; f0 = n_frame; t0 = n_to; o0 = n_ovr;
        foreach (stream[k]) begin
            send_byte(stream[k]);
            repeat ($urandom_range(0, 2)) begin
                pkt_if.pkt_ready = 1'($urandom);
                tick_clk();
            end
            drain(1'b1);
        end
        repeat (2) tick_clk();
        chk("rnd_size", 32'(got_q.size() - base), 32'(exp_q.size()));
        foreach (exp_q[k]) chk("rnd_beat", 32'(got_q[base+k]), 32'(exp_q[k]));
        chk("rnd_chk_err", 32'(n_chk - c0), 32'(exp_chk));
        chk("rnd_len_err", 32'(n_len - l0), 32'(exp_len));
        chk("rnd_other_err", 32'((n_frame - f0) + (n_to - t0) + (n_ovr - o0)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
